// File: rtl/freq_sweep_pkg.sv
// Shared types for the frequency sweep controller and its helpers.
package freq_sweep_pkg;

    // Controller phases: waiting for a request, holding a word, completion pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    // Sweep direction, decided once when the sweep is accepted.
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } sweep_dir_e;

endpackage

// File: rtl/freq_sweep_ctrl_dwell_timer.sv
// Down-counter that measures how long each frequency word is held.
// Loading N makes expire_o assert N cycles later, which gives a hold of N+1 cycles.
module dwell_timer #(
    parameter int DwellWidth = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DwellWidth-1:0] load_val_i,
    output logic                  expire_o
);

    logic [DwellWidth-1:0] count_q;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - DwellWidth'(1);
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Steps a frequency select word from a start value toward a stop value,
// holding each word for a programmable number of cycles.
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int DataWidth  = 8,
    parameter int DwellWidth = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DataWidth-1:0]  start_sel,
    input  logic [DataWidth-1:0]  stop_sel,
    input  logic [DataWidth-1:0]  step,
    input  logic [DwellWidth-1:0] dwell,
    output logic [DataWidth-1:0]  freq_sel,
    output logic                  gen_rst,
    output logic                  busy,
    output logic                  sweep_tick,
    output logic                  done
);

    sweep_state_e          state_q, state_d;
    sweep_dir_e            dir_q, dir_d;
    logic [DataWidth-1:0]  freq_q, freq_d;
    logic [DataWidth-1:0]  stop_q, stop_d;
    logic [DataWidth-1:0]  step_q, step_d;
    logic [DwellWidth-1:0] reload_q, reload_d;
    logic                  gen_rst_q, gen_rst_d;
    logic                  tick_q, tick_d;

    logic                  timerLoad;
    logic [DwellWidth-1:0] timerVal;
    logic                  timerExpire;
    logic [DataWidth:0]    sumUp;
    logic [DataWidth:0]    diffDown;
    logic [DataWidth-1:0]  nextFreq;

    dwell_timer #(
        .DwellWidth(DwellWidth)
    ) u_dwell_timer (
        .clk_in    (clk_in),
        .rst       (rst),
        .load_i    (timerLoad),
        .load_val_i(timerVal),
        .expire_o  (timerExpire)
    );

    // Next word toward stop, computed one bit wider so it can be clamped instead of wrapping.
    always_comb begin
        sumUp    = {1'b0, freq_q} + {1'b0, step_q};
        diffDown = {1'b0, freq_q} - {1'b0, step_q};
        nextFreq = stop_q;
        if (step_q != '0) begin
            if (dir_q == UP) begin
                if (sumUp < {1'b0, stop_q}) begin
                    nextFreq = sumUp[DataWidth-1:0];
                end
            end else begin
                if (!diffDown[DataWidth] && (diffDown[DataWidth-1:0] > stop_q)) begin
                    nextFreq = diffDown[DataWidth-1:0];
                end
            end
        end
    end

    // Sequencing: accept a sweep, advance the word when a hold expires, abort from anywhere.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        freq_d    = freq_q;
        stop_d    = stop_q;
        step_d    = step_q;
        reload_d  = reload_q;
        gen_rst_d = 1'b0;
        tick_d    = 1'b0;
        timerLoad = 1'b0;
        timerVal  = reload_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = DWELL;
                    freq_d    = start_sel;
                    stop_d    = stop_sel;
                    step_d    = step;
                    dir_d     = (stop_sel >= start_sel) ? UP : DOWN;
                    reload_d  = (dwell == '0) ? '0 : dwell - DwellWidth'(1);
                    gen_rst_d = 1'b1;
                    timerLoad = 1'b1;
                    timerVal  = reload_d;
                end
            end
            DWELL: begin
                if (timerExpire) begin
                    if (freq_q == stop_q) begin
                        state_d = DONE;
                    end else begin
                        freq_d    = nextFreq;
                        tick_d    = 1'b1;
                        timerLoad = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d   = IDLE;
            freq_d    = freq_q;
            gen_rst_d = 1'b0;
            tick_d    = 1'b0;
            timerLoad = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= UP;
            freq_q    <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            reload_q  <= '0;
            gen_rst_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            freq_q    <= freq_d;
            stop_q    <= stop_d;
            step_q    <= step_d;
            reload_q  <= reload_d;
            gen_rst_q <= gen_rst_d;
            tick_q    <= tick_d;
        end
    end

    assign freq_sel   = freq_q;
    assign gen_rst    = gen_rst_q;
    assign sweep_tick = tick_q;
    assign busy       = (state_q == DWELL);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl against a sweep-list reference model.
module tb_freq_sweep_ctrl;

    logic        clk_in;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  start_sel;
    logic [7:0]  stop_sel;
    logic [7:0]  step;
    logic [15:0] dwell;
    logic [7:0]  freq_sel;
    logic        gen_rst;
    logic        busy;
    logic        sweep_tick;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int freq;
        bit genRst;
        bit tick;
        bit busy;
        bit done;
    } expRec;

    expRec expQ[$];
    expRec cur;

    freq_sweep_ctrl #(
        .DataWidth (8),
        .DwellWidth(16)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .start_sel (start_sel),
        .stop_sel  (stop_sel),
        .step      (step),
        .dwell     (dwell),
        .freq_sel  (freq_sel),
        .gen_rst   (gen_rst),
        .busy      (busy),
        .sweep_tick(sweep_tick),
        .done      (done)
    );

    // Free-running clock, 10 time units per period.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic expRec mkRec(int f, bit g, bit t, bit b, bit d);
        expRec r;
        r.freq   = f;
        r.genRst = g;
        r.tick   = t;
        r.busy   = b;
        r.done   = d;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("freq_sel", int'(freq_sel), cur.freq);
        checkOutput("gen_rst", int'(gen_rst), int'(cur.genRst));
        checkOutput("sweep_tick", int'(sweep_tick), int'(cur.tick));
        checkOutput("busy", int'(busy), int'(cur.busy));
        checkOutput("done", int'(done), int'(cur.done));
    endtask

    // Expand an accepted request into the full cycle-by-cycle list of expected outputs.
    task automatic buildSweep(input int s, input int e, input int st, input int dw);
        int  v;
        int  d;
        int  idx;
        bit  up;
        v   = s;
        d   = (dw == 0) ? 1 : dw;
        up  = (e >= s);
        idx = 0;
        forever begin
            for (int j = 0; j < d; j++)
                expQ.push_back(mkRec(v, (idx == 0) && (j == 0), (idx > 0) && (j == 0), 1'b1, 1'b0));
            if (v == e) break;
            if (st == 0)      v = e;
            else if (up)      v = (v + st > e) ? e : v + st;
            else              v = (v - st < e) ? e : v - st;
            idx++;
        end
        expQ.push_back(mkRec(e, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    // Advance the reference by one rising edge using the inputs the DUT just sampled.
    task automatic modelStep();
        if (abort) begin
            expQ.delete();
            cur = mkRec(cur.freq, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (expQ.size() > 0) begin
            cur = expQ.pop_front();
        end else if (!cur.busy && !cur.done && start) begin
            buildSweep(int'(start_sel), int'(stop_sel), int'(step), int'(dwell));
            cur = expQ.pop_front();
        end else begin
            cur = mkRec(cur.freq, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One clock: check current outputs, drive new inputs, then follow the edge in the model.
    task automatic applyStimulus(input bit s, input bit a, input logic [7:0] ss,
                                 input logic [7:0] sp, input logic [7:0] st, input logic [15:0] dw);
        @(negedge clk_in);
        compareAll();
        start     = s;
        abort     = a;
        start_sel = ss;
        stop_sel  = sp;
        step      = st;
        dwell     = dw;
        @(posedge clk_in);
        modelStep();
    endtask

    // Issue one request and run until the model says the sweep has finished.
    task automatic runSweep(input logic [7:0] ss, input logic [7:0] sp,
                            input logic [7:0] st, input logic [15:0] dw);
        int budget;
        applyStimulus(1'b1, 1'b0, ss, sp, st, dw);
        budget = 0;
        while (expQ.size() > 0 && budget < 2000) begin
            applyStimulus(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom_range(0, 5)));
            budget++;
        end
        checkOutput("sweep_bounded", budget < 2000 ? 1 : 0, 1);
        repeat (2) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);
    endtask

    // Assert reset between edges and confirm outputs clear without waiting for a clock.
    task automatic pulseReset();
        @(negedge clk_in);
        #2;
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
        expQ.delete();
        cur = mkRec(0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        compareAll();
        @(posedge clk_in);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        start_sel = '0;
        stop_sel  = '0;
        step      = '0;
        dwell     = '0;
        cur       = mkRec(0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        compareAll();
        @(posedge clk_in);
        #2;
        rst = 1'b0;

        runSweep(8'd10, 8'd40, 8'd10, 16'd3);
        runSweep(8'd10, 8'd35, 8'd10, 16'd2);
        runSweep(8'd200, 8'd50, 8'd100, 16'd1);
        runSweep(8'd250, 8'd255, 8'd10, 16'd1);
        runSweep(8'd7, 8'd7, 8'd0, 16'd0);
        runSweep(8'd5, 8'd60, 8'd0, 16'd2);
        runSweep(8'd3, 8'd0, 8'd200, 16'd2);

        // Abort during the second hold while start is held high through the sweep.
        applyStimulus(1'b1, 1'b0, 8'd10, 8'd40, 8'd10, 16'd3);
        repeat (4) applyStimulus(1'b1, 1'b0, 8'd90, 8'd91, 8'd1, 16'd1);
        applyStimulus(1'b1, 1'b1, 8'd90, 8'd91, 8'd1, 16'd1);
        repeat (4) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);

        // Start and abort together in IDLE must not launch a sweep.
        applyStimulus(1'b1, 1'b1, 8'd20, 8'd30, 8'd5, 16'd1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);

        // Reset in the middle of a dwell, then a clean sweep afterwards.
        applyStimulus(1'b1, 1'b0, 8'd10, 8'd40, 8'd10, 16'd3);
        repeat (4) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);
        pulseReset();
        runSweep(8'd10, 8'd40, 8'd10, 16'd3);

        // Random traffic with occasional aborts and resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) pulseReset();
            applyStimulus(($urandom % 4) == 0, ($urandom % 64) == 0,
                          8'($urandom), 8'($urandom),
                          8'($urandom_range(0, 90)), 16'($urandom_range(0, 4)));
        end
        repeat (3) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 16'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
